// File: rtl/mem_endpoint_programmer_pkg.sv
// Shared types for the endpoint-table control path: command/status encodings,
// the 131-bit ep_ctrl write format and the programmer FSM state set.
package mem_endpoint_programmer_pkg;

    localparam int EP_CTRL_BITS  = 131;
    localparam int EP_ADDR_BITS  = 48;
    localparam int EP_BASE_LSB   = 0;
    localparam int EP_BOUND_LSB  = 48;
    localparam int EP_RSVD_LSB   = 96;
    localparam int EP_IDX_LSB    = 122;
    localparam int EP_RIGHTS_LSB = 127;
    localparam int EP_VALID_BIT  = 129;
    localparam int EP_STROBE_BIT = 130;

    typedef enum logic [1:0] {
        EP_OP_GRANT      = 2'd0,
        EP_OP_REVOKE     = 2'd1,
        EP_OP_REVOKE_ALL = 2'd2,
        EP_OP_ILLEGAL    = 2'd3
    } ep_cmd_op_t;

    typedef enum logic [2:0] {
        EP_OK          = 3'd0,
        EP_ERR_IDX     = 3'd1,
        EP_ERR_RIGHTS  = 3'd2,
        EP_ERR_RANGE   = 3'd3,
        EP_ERR_OVERLAP = 3'd4,
        EP_ERR_OP      = 3'd5
    } ep_status_t;

    typedef struct packed {
        logic        strobe;
        logic        valid;
        logic [1:0]  rights;
        logic [4:0]  idx;
        logic [25:0] rsvd;
        logic [47:0] bound;
        logic [47:0] base;
    } ep_ctrl_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_SCAN  = 3'd2,
        S_WRITE = 3'd3,
        S_SWEEP = 3'd4,
        S_RESP  = 3'd5
    } ep_fsm_t;

    function automatic ep_ctrl_t ep_ctrl_strobe(input logic        valid,
                                                input logic [1:0]  rights,
                                                input logic [4:0]  idx,
                                                input logic [47:0] bound,
                                                input logic [47:0] base);
        ep_ctrl_t c;
        c.strobe = 1'b1;
        c.valid  = valid;
        c.rights = rights;
        c.idx    = idx;
        c.rsvd   = '0;
        c.bound  = bound;
        c.base   = base;
        return c;
    endfunction

endpackage

// File: rtl/mem_endpoint_programmer_overlap.sv
// Inclusive range intersection: true when [a_base,a_bound] and [b_base,b_bound]
// share at least one address. Pure unsigned compares, no subtraction.
module ep_range_overlap #(
    parameter int ADDR_BITS = 48
) (
    input  logic [ADDR_BITS-1:0] a_base_i,
    input  logic [ADDR_BITS-1:0] a_bound_i,
    input  logic [ADDR_BITS-1:0] b_base_i,
    input  logic [ADDR_BITS-1:0] b_bound_i,
    output logic                 overlap_o
);

    assign overlap_o = (a_base_i <= b_bound_i) && (b_base_i <= a_bound_i);

endmodule

// File: rtl/mem_endpoint_programmer.sv
// Endpoint-table programmer: validates grant/revoke commands against a shadow
// table, emits one-cycle ep_ctrl write strobes and answers with a status.
module mem_endpoint_programmer
    import mem_endpoint_programmer_pkg::*;
#(
    parameter int N_ENDPOINTS = 4,
    parameter int VADDR_BITS  = 48
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    s_cmd_valid,
    output logic                    s_cmd_ready,
    input  logic [1:0]              s_cmd_op,
    input  logic [4:0]              s_cmd_idx,
    input  logic [1:0]              s_cmd_rights,
    input  logic [VADDR_BITS-1:0]   s_cmd_base,
    input  logic [VADDR_BITS-1:0]   s_cmd_bound,
    output logic                    m_rsp_valid,
    input  logic                    m_rsp_ready,
    output logic [2:0]              m_rsp_status,
    output logic [4:0]              m_rsp_idx,
    output logic [EP_CTRL_BITS-1:0] ep_ctrl,
    output logic [N_ENDPOINTS-1:0]  active_mask,
    output logic                    busy
);

    localparam int         PW   = (N_ENDPOINTS > 1) ? $clog2(N_ENDPOINTS) : 1;
    localparam logic [4:0] LAST = 5'(N_ENDPOINTS - 1);
    localparam logic [5:0] NEP  = 6'(N_ENDPOINTS);

    ep_fsm_t    state_q;
    logic [4:0] ptr_q;
    ep_ctrl_t   ep_ctrl_q;
    ep_status_t rsp_status_q;
    logic [4:0] rsp_idx_q;

    logic [N_ENDPOINTS-1:0]                 shd_vld_q;
    logic [N_ENDPOINTS-1:0][VADDR_BITS-1:0] shd_base_q;
    logic [N_ENDPOINTS-1:0][VADDR_BITS-1:0] shd_bound_q;

    ep_cmd_op_t            cmd_op_q;
    logic [4:0]            cmd_idx_q;
    logic [1:0]            cmd_rights_q;
    logic [VADDR_BITS-1:0] cmd_base_q;
    logic [VADDR_BITS-1:0] cmd_bound_q;

    logic          cmd_accept;
    logic          range_ok;
    logic          scan_ovl;
    logic          scan_hit;
    logic          idx_bad;
    logic [PW-1:0] ptr_sel;
    logic [PW-1:0] cmd_sel;

    assign cmd_accept = s_cmd_valid && (state_q == S_IDLE);
    assign ptr_sel    = ptr_q[PW-1:0];
    assign cmd_sel    = cmd_idx_q[PW-1:0];
    assign idx_bad    = {1'b0, cmd_idx_q} >= NEP;

    // Degenerate range [base,base] against [0,bound] intersects exactly when base <= bound.
    ep_range_overlap #(.ADDR_BITS(VADDR_BITS)) u_range_chk (
        .a_base_i  (cmd_base_q),
        .a_bound_i (cmd_base_q),
        .b_base_i  ({VADDR_BITS{1'b0}}),
        .b_bound_i (cmd_bound_q),
        .overlap_o (range_ok)
    );

    ep_range_overlap #(.ADDR_BITS(VADDR_BITS)) u_scan_chk (
        .a_base_i  (shd_base_q[ptr_sel]),
        .a_bound_i (shd_bound_q[ptr_sel]),
        .b_base_i  (cmd_base_q),
        .b_bound_i (cmd_bound_q),
        .overlap_o (scan_ovl)
    );

    assign scan_hit = shd_vld_q[ptr_sel] && (ptr_q != cmd_idx_q) && scan_ovl;

    always_ff @(posedge aclk) begin
        if (cmd_accept) begin
            cmd_op_q     <= ep_cmd_op_t'(s_cmd_op);
            cmd_idx_q    <= s_cmd_idx;
            cmd_rights_q <= s_cmd_rights;
            cmd_base_q   <= s_cmd_base;
            cmd_bound_q  <= s_cmd_bound;
        end
    end

    // The strobe is loaded on the transition into WRITE/SWEEP so it is visible
    // during that state's cycle and dropped again by the default below.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            ep_ctrl_q    <= '0;
            rsp_status_q <= EP_OK;
            rsp_idx_q    <= '0;
            shd_vld_q    <= '0;
            shd_base_q   <= '0;
            shd_bound_q  <= '0;
        end else begin
            ep_ctrl_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_accept) state_q <= S_CHECK;
                end
                S_CHECK: begin
                    rsp_idx_q <= cmd_idx_q;
                    if (cmd_op_q == EP_OP_ILLEGAL) begin
                        rsp_status_q <= EP_ERR_OP;
                        state_q      <= S_RESP;
                    end else if (idx_bad) begin
                        rsp_status_q <= EP_ERR_IDX;
                        state_q      <= S_RESP;
                    end else if (cmd_op_q == EP_OP_GRANT && cmd_rights_q == 2'b00) begin
                        rsp_status_q <= EP_ERR_RIGHTS;
                        state_q      <= S_RESP;
                    end else if (cmd_op_q == EP_OP_GRANT && !range_ok) begin
                        rsp_status_q <= EP_ERR_RANGE;
                        state_q      <= S_RESP;
                    end else if (cmd_op_q == EP_OP_GRANT) begin
                        ptr_q   <= '0;
                        state_q <= S_SCAN;
                    end else if (cmd_op_q == EP_OP_REVOKE) begin
                        ep_ctrl_q <= ep_ctrl_strobe(1'b0, cmd_rights_q, cmd_idx_q,
                                                    EP_ADDR_BITS'(cmd_bound_q),
                                                    EP_ADDR_BITS'(cmd_base_q));
                        state_q   <= S_WRITE;
                    end else begin
                        ep_ctrl_q <= ep_ctrl_strobe(1'b0, 2'b00, 5'd0, '0, '0);
                        ptr_q     <= '0;
                        state_q   <= S_SWEEP;
                    end
                end
                S_SCAN: begin
                    if (scan_hit) begin
                        rsp_status_q <= EP_ERR_OVERLAP;
                        state_q      <= S_RESP;
                    end else if (ptr_q == LAST) begin
                        ep_ctrl_q <= ep_ctrl_strobe(1'b1, cmd_rights_q, cmd_idx_q,
                                                    EP_ADDR_BITS'(cmd_bound_q),
                                                    EP_ADDR_BITS'(cmd_base_q));
                        state_q   <= S_WRITE;
                    end else begin
                        ptr_q <= ptr_q + 5'd1;
                    end
                end
                S_WRITE: begin
                    shd_vld_q[cmd_sel]   <= (cmd_op_q == EP_OP_GRANT);
                    shd_base_q[cmd_sel]  <= cmd_base_q;
                    shd_bound_q[cmd_sel] <= cmd_bound_q;
                    rsp_status_q         <= EP_OK;
                    state_q              <= S_RESP;
                end
                S_SWEEP: begin
                    shd_vld_q[ptr_sel]   <= 1'b0;
                    shd_base_q[ptr_sel]  <= '0;
                    shd_bound_q[ptr_sel] <= '0;
                    if (ptr_q == LAST) begin
                        rsp_status_q <= EP_OK;
                        rsp_idx_q    <= '0;
                        state_q      <= S_RESP;
                    end else begin
                        ep_ctrl_q <= ep_ctrl_strobe(1'b0, 2'b00, ptr_q + 5'd1, '0, '0);
                        ptr_q     <= ptr_q + 5'd1;
                    end
                end
                S_RESP: begin
                    if (m_rsp_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_cmd_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign m_rsp_valid  = (state_q == S_RESP);
    assign m_rsp_status = rsp_status_q;
    assign m_rsp_idx    = rsp_idx_q;
    assign ep_ctrl      = ep_ctrl_q;
    assign active_mask  = shd_vld_q;

endmodule

// File: tb/tb_mem_endpoint_programmer.sv
// Directed bench for mem_endpoint_programmer (N=4) with a cycle-level
// command model and per-cycle output comparison.
module tb_mem_endpoint_programmer;

    localparam int N = 4;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         s_cmd_valid = 1'b0;
    logic         s_cmd_ready;
    logic [1:0]   s_cmd_op = '0;
    logic [4:0]   s_cmd_idx = '0;
    logic [1:0]   s_cmd_rights = '0;
    logic [47:0]  s_cmd_base = '0;
    logic [47:0]  s_cmd_bound = '0;
    logic         m_rsp_valid;
    logic         m_rsp_ready = 1'b1;
    logic [2:0]   m_rsp_status;
    logic [4:0]   m_rsp_idx;
    logic [130:0] ep_ctrl;
    logic [3:0]   active_mask;
    logic         busy;

    mem_endpoint_programmer #(.N_ENDPOINTS(N), .VADDR_BITS(48)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_cmd_valid  (s_cmd_valid),
        .s_cmd_ready  (s_cmd_ready),
        .s_cmd_op     (s_cmd_op),
        .s_cmd_idx    (s_cmd_idx),
        .s_cmd_rights (s_cmd_rights),
        .s_cmd_base   (s_cmd_base),
        .s_cmd_bound  (s_cmd_bound),
        .m_rsp_valid  (m_rsp_valid),
        .m_rsp_ready  (m_rsp_ready),
        .m_rsp_status (m_rsp_status),
        .m_rsp_idx    (m_rsp_idx),
        .ep_ctrl      (ep_ctrl),
        .active_mask  (active_mask),
        .busy         (busy)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [130:0] act, input logic [130:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model state: expected strobes by cycle, the pending response and the entry table.
    logic [130:0] exp_ctrl [int];
    bit           pending = 0;
    int           rsp_t = 0;
    int           busy_start = 0;
    logic [2:0]   exp_st = '0;
    logic [4:0]   exp_idx = '0;
    bit           m_v [N];
    logic [47:0]  m_b [N];
    logic [47:0]  m_bd [N];
    logic [3:0]   mask_m = '0;
    int           last_T = 0;

    task automatic model_cmd(input int T, input int op, input int idx, input logic [1:0] r,
                             input logic [47:0] b, input logic [47:0] bd);
        int p;
        exp_idx    = 5'(idx);
        busy_start = T + 1;
        pending    = 1;
        if (op == 3) exp_st = 3'd5;
        else if (idx >= N) exp_st = 3'd1;
        else if (op == 0 && r == 2'b00) exp_st = 3'd2;
        else if (op == 0 && bd < b) exp_st = 3'd3;
        else exp_st = 3'd0;
        if (exp_st != 3'd0) begin
            rsp_t = T + 2;
        end else if (op == 0) begin
            p = -1;
            for (int q = 0; q < N; q++)
                if (p < 0 && m_v[q] && q != idx && m_b[q] <= bd && b <= m_bd[q]) p = q;
            if (p >= 0) begin
                exp_st = 3'd4;
                rsp_t  = T + 3 + p;
            end else begin
                exp_ctrl[T+N+2] = {1'b1, 1'b1, r, 5'(idx), 26'd0, bd, b};
                rsp_t = T + N + 3;
                m_v[idx] = 1; m_b[idx] = b; m_bd[idx] = bd;
            end
        end else if (op == 1) begin
            exp_ctrl[T+2] = {1'b1, 1'b0, r, 5'(idx), 26'd0, bd, b};
            rsp_t = T + 3;
            m_v[idx] = 0;
        end else begin
            for (int k = 0; k < N; k++) exp_ctrl[T+2+k] = {1'b1, 1'b0, 2'b00, 5'(k), 26'd0, 96'd0};
            rsp_t   = T + N + 2;
            exp_idx = '0;
            for (int k = 0; k < N; k++) m_v[k] = 0;
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    bit           chk_en = 0;
    logic [130:0] e_ctrl;
    bit           e_v, e_b, prev_rv = 0;
    int           rsp_first_cyc = 0;
    int           n_strb = 0;
    logic [130:0] last_strb = '0;
    int           last_strb_cyc = 0;

    always @(negedge aclk) begin
        if (chk_en) begin
            e_ctrl = exp_ctrl.exists(cyc) ? exp_ctrl[cyc] : '0;
            e_v = pending && (cyc >= rsp_t);
            e_b = pending && (cyc >= busy_start);
            chk("ep_ctrl", ep_ctrl, e_ctrl);
            chki("m_rsp_valid", int'(m_rsp_valid), int'(e_v));
            if (e_v) begin
                chki("m_rsp_status", int'(m_rsp_status), int'(exp_st));
                chki("m_rsp_idx", int'(m_rsp_idx), int'(exp_idx));
            end
            chki("busy", int'(busy), int'(e_b));
            chki("s_cmd_ready", int'(s_cmd_ready), int'(!e_b));
            chki("active_mask", int'(active_mask), int'(mask_m));
            if (e_ctrl[130]) mask_m[e_ctrl[123:122]] = e_ctrl[129];
            if (ep_ctrl[130]) begin
                n_strb++;
                last_strb     = ep_ctrl;
                last_strb_cyc = cyc;
            end
            if (m_rsp_valid && !prev_rv) rsp_first_cyc = cyc;
            prev_rv = m_rsp_valid;
            if (e_v && m_rsp_ready) pending = 0;
        end
    end

    // Caller is positioned just after a rising edge.
    task automatic send(input int op, input int idx, input logic [1:0] r,
                        input logic [47:0] b, input logic [47:0] bd);
        int k;
        s_cmd_valid = 1'b1; s_cmd_op = 2'(op); s_cmd_idx = 5'(idx);
        s_cmd_rights = r; s_cmd_base = b; s_cmd_bound = bd;
        k = 0;
        while (!s_cmd_ready && k < 300) begin
            @(posedge aclk); #1; k++;
        end
        if (!s_cmd_ready) begin
            chki("accept_timeout", 0, 1);
            s_cmd_valid = 1'b0;
            return;
        end
        last_T = cyc;
        model_cmd(cyc, op, idx, r, b, bd);
        @(posedge aclk); #1;
        s_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (pending && k < 300) begin
            @(posedge aclk); #1; k++;
        end
        if (pending) chki("rsp_timeout", 0, 1);
    endtask

    int s0, rel_cyc;

    initial begin
        for (int q = 0; q < N; q++) begin m_v[q] = 0; m_b[q] = '0; m_bd[q] = '0; end
        repeat (3) @(posedge aclk);
        #1;
        chki("rst_s_cmd_ready", int'(s_cmd_ready), 1);
        chki("rst_m_rsp_valid", int'(m_rsp_valid), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_active_mask", int'(active_mask), 0);
        chk("rst_ep_ctrl", ep_ctrl, '0);
        areset = 1'b0;
        chk_en = 1;
        @(posedge aclk); #1;

        // First grant: strobe at T+6, response at T+7.
        send(0, 0, 2'b01, 48'h1000, 48'h1FFF);
        wait_idle();
        chki("g0_strobe_lat", last_strb_cyc - last_T, 6);
        chk("g0_ctrl", last_strb, {1'b1, 1'b1, 2'b01, 5'd0, 26'd0, 48'h1FFF, 48'h1000});
        chki("g0_rsp_lat", rsp_first_cyc - last_T, 7);
        chki("g0_mask", int'(active_mask), 4'b0001);

        s0 = n_strb;
        send(0, 1, 2'b01, 48'h1800, 48'h27FF);
        wait_idle();
        chki("ovl_no_strobe", n_strb - s0, 0);
        chki("ovl_mask", int'(active_mask), 4'b0001);

        send(0, 0, 2'b11, 48'h1000, 48'h2FFF);
        wait_idle();
        chk("regrant_ctrl", last_strb, {1'b1, 1'b1, 2'b11, 5'd0, 26'd0, 48'h2FFF, 48'h1000});

        s0 = n_strb;
        send(0, 4, 2'b01, 48'h8000, 48'h8FFF);
        wait_idle();
        chki("erridx_lat", rsp_first_cyc - last_T, 2);
        send(0, 1, 2'b01, 48'h2000, 48'h1FFF);
        wait_idle();
        chki("errrange_lat", rsp_first_cyc - last_T, 2);
        send(0, 1, 2'b00, 48'h8000, 48'h8FFF);
        wait_idle();
        send(3, 1, 2'b01, 48'h8000, 48'h8FFF);
        wait_idle();
        chki("err_no_strobe", n_strb - s0, 0);

        send(0, 1, 2'b10, 48'h4000, 48'h4FFF);
        wait_idle();
        chki("pre_sweep_mask", int'(active_mask), 4'b0011);
        s0 = n_strb;
        send(2, 3, 2'b00, 48'h0, 48'h0);
        wait_idle();
        chki("sweep_strobes", n_strb - s0, 4);
        chki("sweep_rsp_lat", rsp_first_cyc - last_T, 6);
        chki("sweep_mask", int'(active_mask), 0);

        send(0, 3, 2'b01, 48'h5000, 48'h5FFF);
        wait_idle();
        send(1, 3, 2'b00, 48'h0, 48'h0);
        wait_idle();
        chki("revoke_strobe_lat", last_strb_cyc - last_T, 2);
        chki("revoke_mask", int'(active_mask), 0);
        send(1, 2, 2'b00, 48'h0, 48'h0);
        wait_idle();

        // Response back-pressure, with a second command waiting behind it.
        send(0, 0, 2'b01, 48'h1000, 48'h1FFF);
        wait_idle();
        m_rsp_ready = 1'b0;
        send(0, 2, 2'b01, 48'h6000, 48'h6FFF);
        fork
            send(0, 0, 2'b01, 48'h7000, 48'h7FFF);
            begin
                repeat (18) @(posedge aclk);
                #1;
                rel_cyc = cyc;
                m_rsp_ready = 1'b1;
            end
        join
        chki("hold_accept_cyc", last_T, rel_cyc + 1);
        wait_idle();
        chki("hold_mask", int'(active_mask), 4'b0101);

        // Asynchronous reset in the middle of an overlap scan.
        send(0, 1, 2'b01, 48'h9000, 48'h9FFF);
        @(posedge aclk); #1;
        chk_en = 0;
        areset = 1'b1;
        #1;
        chk("arst_ep_ctrl", ep_ctrl, '0);
        chki("arst_rsp_valid", int'(m_rsp_valid), 0);
        chki("arst_busy", int'(busy), 0);
        chki("arst_mask", int'(active_mask), 0);
        exp_ctrl.delete();
        pending = 0;
        mask_m  = '0;
        prev_rv = 0;
        for (int q = 0; q < N; q++) m_v[q] = 0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk); #1;
        chk_en = 1;
        send(0, 1, 2'b01, 48'h9000, 48'h9FFF);
        wait_idle();
        chki("post_rst_grant_lat", last_strb_cyc - last_T, 6);
        chki("post_rst_mask", int'(active_mask), 4'b0010);

        repeat (3) @(posedge aclk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
